// File: rtl/stream_mux_rr_if.sv
// Bundle of the N:1 stream mux signals: per-channel input streams,
// arbitration controls and the single registered output stream.
interface stream_mux_rr_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) ();
    localparam int SEL_W = $clog2(NCH);

    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_last;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_last;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_ready;

    // Source side: drives the input streams and controls, consumes the output.
    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );

    // Mux side.
    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 packet stream multiplexer with round-robin or fixed-select arbitration.
// A packet, once started, locks the grant to its channel until its last beat.
// Output is a single register stage (1-cycle latency, full throughput).
module stream_mux_rr #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    stream_mux_rr_if.slave   bus
);
    localparam int SEL_W = $clog2(NCH);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   rr_ptr_reg;
    logic [SEL_W-1:0]   lock_ch_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic [SEL_W-1:0]   out_ch_reg;

    logic [WIDTH-1:0]   ch_data [NCH];
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [WIDTH-1:0]   grant_data;
    logic               grant_last;
    logic               load;
    logic               in_xfer;

    // Output register can take a new beat when empty or being drained.
    // rst_n gating keeps in_ready low for the whole reset assertion.
    assign load    = ~out_valid_reg | bus.out_ready;
    assign in_xfer = rst_n & load & grant_valid;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
            assign bus.in_ready[gi] = rst_n & load & grant_valid &
                                      (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Pick the granted channel: locked channel, fixed select, or rotating search.
    always_comb begin
        int k;
        grant_idx   = '0;
        grant_valid = 1'b0;
        k           = 0;
        if (state_reg == LOCKED) begin
            grant_idx = lock_ch_reg;
            for (int i = 0; i < NCH; i++) begin
                if (lock_ch_reg == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_valid = 1'b1;
                end
            end
        end else if (bus.mode) begin
            // Loop compare so out-of-range sel values simply match nothing.
            for (int i = 0; i < NCH; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_idx   = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                k = (int'(rr_ptr_reg) + i) % NCH;
                if (!grant_valid && bus.in_valid[k]) begin
                    grant_idx   = SEL_W'(k);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Route the granted channel's beat toward the output register.
    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = ch_data[i];
                grant_last = bus.in_last[i];
            end
        end
    end

    // Packet-lock FSM, round-robin pointer and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            lock_ch_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
        end else begin
            if (in_xfer) begin
                out_data_reg  <= grant_data;
                out_last_reg  <= grant_last;
                out_ch_reg    <= grant_idx;
                out_valid_reg <= 1'b1;
                case (state_reg)
                    IDLE: begin
                        if (!grant_last) begin
                            state_reg   <= LOCKED;
                            lock_ch_reg <= grant_idx;
                        end
                    end
                    LOCKED: begin
                        if (grant_last) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
                if (grant_last) begin
                    rr_ptr_reg <= (grant_idx == SEL_W'(NCH-1)) ? '0 : grant_idx + 1'b1;
                end
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_ch    = out_ch_reg;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel build for the main checks and
// a 3-channel build for the out-of-range fixed select.
module tb_stream_mux_rr;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    stream_mux_rr_if #(.NCH(4), .WIDTH(8)) b4 ();
    stream_mux_rr_if #(.NCH(3), .WIDTH(8)) b3 ();

    stream_mux_rr #(.NCH(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    stream_mux_rr #(.NCH(3), .WIDTH(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
        if (b4.out_valid)
            $display("beat ch=%0d data=%02h last=%0b", b4.out_ch, b4.out_data, b4.out_last);
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        b4.in_data = {d3, d2, d1, d0};
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b4.mode = 1'b0; b4.sel = '0; b4.in_valid = 4'b1111; b4.in_last = 4'b1111;
        b4.out_ready = 1'b1;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        b3.mode = 1'b1; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.in_last = 3'b111;
        b3.in_data = 24'h333231; b3.out_ready = 1'b1;

        // 1: reset state with inputs active
        #2;
        chk("rst_in_ready", b4.in_ready, 4'b0000);
        chk("rst_out_valid", b4.out_valid, 0);
        chk("rst_out_data", b4.out_data, 0);
        chk("rst_out_ch", b4.out_ch, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2: round-robin over single-beat packets, one beat per cycle
        #1;
        chk("rr_first_ready", b4.in_ready, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rr_valid", b4.out_valid, 1);
            chk("rr_ch", b4.out_ch, i % 4);
            chk("rr_data", b4.out_data, 8'h10 + (i % 4));
        end
        b4.in_valid = 4'b0000;
        tick;
        chk("rr_drain", b4.out_valid, 0);

        // 3: ch1 3-beat packet locks out ch2 (rr_ptr is 1 now)
        b4.in_valid = 4'b0110;
        b4.in_last  = 4'b0100;
        set_data(8'h00, 8'h21, 8'h30, 8'h00);
        #1;
        chk("lock_ready1", b4.in_ready, 4'b0010);
        tick;
        chk("lock_b1", {b4.out_ch, b4.out_data}, {2'd1, 8'h21});
        set_data(8'h00, 8'h22, 8'h30, 8'h00);
        #1;
        chk("lock_ready2", b4.in_ready, 4'b0010);
        tick;
        chk("lock_b2", {b4.out_ch, b4.out_data}, {2'd1, 8'h22});
        set_data(8'h00, 8'h23, 8'h30, 8'h00);
        b4.in_last = 4'b0110;
        #1;
        chk("lock_ready3", b4.in_ready, 4'b0010);
        tick;
        chk("lock_b3", {b4.out_ch, b4.out_data, b4.out_last}, {2'd1, 8'h23, 1'b1});
        chk("lock_ch2_ready", b4.in_ready, 4'b0100);
        b4.in_valid = 4'b0100;
        tick;
        chk("lock_ch2_beat", {b4.out_ch, b4.out_data, b4.out_last}, {2'd2, 8'h30, 1'b1});
        b4.in_valid = 4'b0000;
        tick;

        // 6: rr_ptr=3, only ch0 valid -> wrap to ch0, then pointer moves to 1
        b4.in_valid = 4'b0001;
        b4.in_last  = 4'b0001;
        set_data(8'h40, 8'h41, 8'h42, 8'h43);
        #1;
        chk("wrap_ready", b4.in_ready, 4'b0001);
        tick;
        chk("wrap_beat", {b4.out_ch, b4.out_data}, {2'd0, 8'h40});
        b4.in_valid = 4'b1111;
        b4.in_last  = 4'b1111;
        #1;
        chk("wrap_ptr1", b4.in_ready, 4'b0010);
        b4.in_valid = 4'b0000;
        tick;

        // 4: fixed select; sel change mid-packet waits for packet end
        b4.mode = 1'b1;
        b4.sel  = 2'd2;
        b4.in_valid = 4'b1111;
        b4.in_last  = 4'b0000;
        set_data(8'h50, 8'h51, 8'h52, 8'h53);
        #1;
        chk("sel_ready", b4.in_ready, 4'b0100);
        tick;
        chk("sel_b1", b4.out_ch, 2);
        b4.sel = 2'd3;
        #1;
        chk("sel_hold_ready", b4.in_ready, 4'b0100);
        tick;
        chk("sel_b2", {b4.out_ch, b4.out_data}, {2'd2, 8'h52});
        b4.in_last = 4'b0100;
        tick;
        chk("sel_b3", {b4.out_ch, b4.out_last}, {2'd2, 1'b1});
        chk("sel_new_ready", b4.in_ready, 4'b1000);
        b4.in_last = 4'b1111;
        tick;
        chk("sel_ch3", {b4.out_ch, b4.out_data}, {2'd3, 8'h53});
        b4.in_valid = 4'b0000;
        b4.mode = 1'b0;
        // NCH=3 build: sel=3 grants nothing, sel=2 grants ch2
        chk("n3_sel3_ready", b3.in_ready, 3'b000);
        chk("n3_sel3_valid", b3.out_valid, 0);
        b3.sel = 2'd2;
        #1;
        chk("n3_sel2_ready", b3.in_ready, 3'b100);
        tick;
        chk("n3_sel2_beat", {b3.out_valid, b3.out_data}, {1'b1, 8'h33});

        // 5: stall with 0xA5 held (rr_ptr is 0 after ch3 packet)
        b4.in_valid  = 4'b0001;
        b4.in_last   = 4'b0001;
        b4.out_ready = 1'b0;
        set_data(8'hA5, 8'h00, 8'h00, 8'h00);
        #1;
        chk("stall_load_ready", b4.in_ready, 4'b0001);
        tick;
        set_data(8'hB6, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", b4.out_data, 8'hA5);
            chk("stall_valid", b4.out_valid, 1);
            chk("stall_ready", b4.in_ready, 4'b0000);
            tick;
        end
        b4.out_ready = 1'b1;
        #1;
        chk("release_ready", b4.in_ready, 4'b0001);
        tick;
        chk("release_next", {b4.out_valid, b4.out_data}, {1'b1, 8'hB6});

        // 1 (cont): asynchronous reset mid-activity
        b4.in_valid  = 4'b1111;
        b4.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", b4.out_valid, 0);
        chk("async_rst_ready", b4.in_ready, 4'b0000);
        chk("async_rst_data", b4.out_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
